// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment display controller.
//
// Scans DIGITS hex digits of a loaded value onto one shared active-low
// segment bus. Each digit is lit for DIV clock cycles. A new value is
// captured into a shadow buffer and copied into the displayed buffer only
// when the scan wraps back to digit 0, so a frame never mixes two values.
//
// Parameters:
//   DIGITS  number of multiplexed digits (1..16)
//   DIV     clock cycles each digit stays lit (>= 2)
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        single-cycle strobe, captures value
//   value       4*DIGITS bits, nibble k drives digit k (k=0 is LSN)
//   segs        {g,f,e,d,c,b,a}, active-low, registered
//   AN          digit enables, active-low one-hot or all-ones, registered
//   frame_done  one-cycle pulse the cycle after the scan wraps to digit 0
//
// Optional feature:
//   SEG_BLANK_LZ_EN  when defined, leading zeros above digit 0 are blanked
//                    (AN all ones, segs 7'h7F during that slot).
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            segs,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_done
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  logic [TW-1:0] tcnt;
  logic [IW-1:0] idx;
  logic [VW-1:0] shadow;
  logic [VW-1:0] active;
  logic          pending;

  logic          tick_c;
  logic          wrap_c;
  logic [3:0]    nib_c;
  logic          blank_c;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // End of a digit slot, and end of the whole frame.
  assign tick_c = (tcnt == TW'(DIV - 1));
  assign wrap_c = tick_c && (idx == IW'(DIGITS - 1));

  // Nibble currently selected by the scan index.
  assign nib_c = active[{idx, 2'b00} +: 4];

  // Per-digit refresh divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (tick_c) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // Digit scan index, wraps DIGITS-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick_c) begin
      if (wrap_c) begin
        idx <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Shadow/active buffers: active only changes at a frame boundary, and a
  // load landing exactly on the boundary bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        shadow <= value;
      end
      if (wrap_c) begin
        if (load) begin
          active <= value;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEG_BLANK_LZ_EN
  logic [DIGITS-1:0] hi_nz_c;

  // hi_nz_c[k] is set when any nibble at position >= k is non-zero.
  always_comb begin : lz_scan
    logic run;
    run     = 1'b0;
    hi_nz_c = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run        = run | (|active[4*k +: 4]);
      hi_nz_c[k] = run;
    end
  end

  // Digit 0 is never blanked so a zero value still shows "0".
  assign blank_c = (idx != '0) && !hi_nz_c[idx];
`else
  assign blank_c = 1'b0;
`endif

  // Registered display outputs, one cycle behind idx/active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs       <= 7'h7F;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap_c;
      if (blank_c) begin
        segs <= 7'h7F;
        AN   <= '1;
      end else begin
        segs <= seg_decode(nib_c);
        AN   <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with DIGITS=4, DIV=4.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [6:0]  segs;
  logic [3:0]  AN;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .segs       (segs),
    .AN         (AN),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment table straight from the digit glyph list.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: n counts rising edges since reset release. The scan
  // position before edge n+1 is n mod FRAME; the frame boundary is the edge
  // leaving position FRAME-1. The displayed value at a boundary becomes the
  // most recent value loaded since the previous boundary (including a load
  // on the boundary edge itself).
  int          n;
  logic [15:0] m_act;
  logic [15:0] last_v;
  logic        have_new;
  logic [3:0]  e_an;
  logic [6:0]  e_segs;
  logic        e_fd;

  always @(posedge clk) begin
    if (!rst_n) begin
      n        = 0;
      m_act    = '0;
      last_v   = '0;
      have_new = 1'b0;
      e_an     = 4'hF;
      e_segs   = 7'h7F;
      e_fd     = 1'b0;
    end else begin
      int pos, d, nib;
      bit blank;
      pos   = n % FRAME;
      d     = pos / DIV;
      nib   = int'((m_act >> (4 * d)) & 16'hF);
      blank = 1'b0;
`ifdef SEG_BLANK_LZ_EN
      blank = (d > 0) && ((m_act >> (4 * d)) == 16'h0);
`endif
      e_an   = blank ? 4'hF : ~(4'b0001 << d);
      e_segs = blank ? 7'h7F : seg_tab[nib];
      e_fd   = (pos == FRAME - 1);
      if (load) begin
        last_v   = value;
        have_new = 1'b1;
      end
      if (pos == FRAME - 1 && have_new) begin
        m_act    = last_v;
        have_new = 1'b0;
      end
      n++;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("an_rst", 32'(AN), 32'h0000000F);
      chk("segs_rst", 32'(segs), 32'h0000007F);
      chk("fd_rst", 32'(frame_done), 32'h0);
    end else begin
      chk("an", 32'(AN), 32'(e_an));
      chk("segs", 32'(segs), 32'(e_segs));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  // Advance to the negedge where the model sits at scan position p.
  task automatic wait_pos(input int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (n % FRAME == p) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL wait_pos: position %0d not reached", p);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_an", 32'(AN), 32'hF);
    chk("lit_rst_segs", 32'(segs), 32'h7F);
    #1 rst_n = 1'b1;

    // Reset release, no load: digit 0 shows "0" at the first edge.
    wait_pos(1);
    chk("lit_first_an", 32'(AN), 32'b1110);
    chk("lit_first_segs", 32'(segs), 32'b1000000);
    wait_pos(5);
    chk("lit_d1_an", 32'(AN), 32'b1101);
    wait_pos(13);
    chk("lit_d3_an", 32'(AN), 32'b0111);
    wait_pos(0);
    chk("lit_fd_pulse", 32'(frame_done), 32'h1);
    wait_pos(1);
    chk("lit_fd_low", 32'(frame_done), 32'h0);

    // Mid-frame load of A5F3: old value until the boundary.
    wait_pos(6);
    do_load(16'hA5F3);
    wait_pos(0);
    chk("lit_a5f3_hold", 32'(segs), 32'b1000000);
    wait_pos(1);
    chk("lit_a5f3_d0", 32'(segs), 32'b0110000);
    wait_pos(5);
    chk("lit_a5f3_d1", 32'(segs), 32'b0001110);
    wait_pos(9);
    chk("lit_a5f3_d2", 32'(segs), 32'b0010010);
    wait_pos(13);
    chk("lit_a5f3_d3", 32'(segs), 32'b0001000);

    // Two loads in one frame: only the second is shown.
    wait_pos(3);
    do_load(16'h1111);
    wait_pos(8);
    do_load(16'h2222);
    wait_pos(1);
    chk("lit_2222_d0", 32'(segs), 32'b0100100);
    wait_pos(14);

    // Load coincident with the frame boundary bypasses the shadow.
    wait_pos(15);
    do_load(16'h0007);
    chk("lit_bypass_pending", 32'(dut.pending), 32'h0);
    wait_pos(1);
    chk("lit_bypass_d0", 32'(segs), 32'b1111000);

    // Leading-zero behaviour with 0070.
    wait_pos(2);
    do_load(16'h0070);
    wait_pos(0);
    wait_pos(1);
    chk("lit_0070_d0", 32'(segs), 32'b1000000);
    wait_pos(5);
    chk("lit_0070_d1_segs", 32'(segs), 32'b1111000);
    chk("lit_0070_d1_an", 32'(AN), 32'b1101);
    wait_pos(9);
`ifdef SEG_BLANK_LZ_EN
    chk("lit_0070_d2_an", 32'(AN), 32'hF);
    chk("lit_0070_d2_segs", 32'(segs), 32'h7F);
`else
    chk("lit_0070_d2_an", 32'(AN), 32'b1011);
    chk("lit_0070_d2_segs", 32'(segs), 32'b1000000);
`endif
    wait_pos(13);
`ifdef SEG_BLANK_LZ_EN
    chk("lit_0070_d3_an", 32'(AN), 32'hF);
`else
    chk("lit_0070_d3_an", 32'(AN), 32'b0111);
`endif

    // Randomised loads, checked every cycle by the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        value = 16'($urandom);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
    wait_pos(0);

    // Reset mid-scan with a load pending: the load is discarded.
    wait_pos(4);
    do_load(16'h1234);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_midrst_an", 32'(AN), 32'hF);
    chk("lit_midrst_segs", 32'(segs), 32'h7F);
    chk("lit_midrst_pending", 32'(dut.pending), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_pos(1);
    chk("lit_postrst_d0", 32'(segs), 32'b1000000);
    wait_pos(0);
    wait_pos(1);
    chk("lit_postrst_frame2", 32'(segs), 32'b1000000);
    wait_pos(9);
    chk("lit_postrst_d2", 32'(segs), 32'b1000000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
